// File: rtl/div_unit_32_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
// Build option: define DIV_FAST_PATH_EN to retire |dividend| < |divisor| early.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W = $clog2(DIV_WIDTH + 1);
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
endpackage

// File: rtl/div_unit_32_if.sv
// Request/result bundle between the EX stage and the divider.
interface div_if import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivByZero;

  modport master (output Start, Signed, Dividend, Divisor,
                  input  Busy, Done, Quotient, Remainder, DivByZero);
  modport slave  (input  Start, Signed, Dividend, Divisor,
                  output Busy, Done, Quotient, Remainder, DivByZero);
endinterface

// File: rtl/div_unit_32_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, restore on borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] sh, trial;

  assign sh    = {rem_i, quo_i[WIDTH-1]};
  assign trial = sh - {1'b0, div_i};
  // A borrow leaves sh below the divisor, so its top bit is zero and can be dropped.
  assign rem_o = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/div_unit_32.sv
// Radix-2 restoring divider for DIV/DIVU; quotient to LO, remainder to HI.
// Build option: DIV_FAST_PATH_EN skips the iterations when |dividend| < |divisor|.
module div_unit_32 import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic  Clk,
  input logic  Rst_n,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic             qsgn_q, rsgn_q, dz_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, remd_q;

  logic             a_neg, b_neg, dz, byp;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign a_neg = bus.Signed & bus.Dividend[WIDTH-1];
  assign b_neg = bus.Signed & bus.Divisor[WIDTH-1];
  assign a_abs = a_neg ? -bus.Dividend : bus.Dividend;
  assign b_abs = b_neg ? -bus.Divisor  : bus.Divisor;
  assign dz    = (bus.Divisor == '0);
`ifdef DIV_FAST_PATH_EN
  assign byp   = dz || (a_abs < b_abs);
`else
  assign byp   = dz;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  // Bypassed ops preload their final result with zero signs and let FIX pass it through.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qsgn_q  <= 1'b0;
      rsgn_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (bus.Start) begin
            state_q <= byp ? FIX : CALC;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            dvs_q   <= b_abs;
            dz_q    <= dz;
            if (byp) begin
              rem_q  <= bus.Dividend;
              quo_q  <= dz ? WIDTH'(DIV0_QUOTIENT) : '0;
              qsgn_q <= 1'b0;
              rsgn_q <= 1'b0;
            end else begin
              rem_q  <= '0;
              quo_q  <= a_abs;
              qsgn_q <= a_neg ^ b_neg;
              rsgn_q <= a_neg;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          quot_q  <= qsgn_q ? -quo_q : quo_q;
          remd_q  <= rsgn_q ? -rem_q : rem_q;
          dbz_q   <= dz_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Quotient  = quot_q;
  assign bus.Remainder = remd_q;
  assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_div_unit_32.sv
// Directed bench for div_unit_32: scoreboard of expected results, latency and stall checks.
module tb_div_unit_32;
  import div_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;
`ifdef DIV_FAST_PATH_EN
  localparam int FPL = 2;
`else
  localparam int FPL = LAT;
`endif

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           at;
    string        tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  div_if #(.WIDTH(W)) bus ();

  div_unit_32 #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request in the current cycle; its Done is due lat cycles later.
  task automatic op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] q, input logic [W-1:0] r, input logic z,
                    input int lat, input string tag);
    exp_t x;
    x.q = q; x.r = r; x.z = z; x.at = cyc + lat; x.tag = tag;
    sb.push_back(x);
    bus.Signed   = s;
    bus.Dividend = a;
    bus.Divisor  = b;
    bus.Start    = 1'b1;
    @(posedge Clk); #1;
    bus.Start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge Clk);
      seen = bus.Done;
    end
    chk({tag, "_seen"}, 64'(seen), 64'(1));
  endtask

  always @(negedge Clk) begin
    if (Rst_n && bus.Done) begin
      chk("done_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, "_quo"},  64'(bus.Quotient),  64'(e.q));
        chk({e.tag, "_rem"},  64'(bus.Remainder), 64'(e.r));
        chk({e.tag, "_dbz"},  64'(bus.DivByZero), 64'(e.z));
        chk({e.tag, "_cyc"},  64'(cyc),           64'(e.at));
        chk({e.tag, "_busy"}, 64'(bus.Busy),      64'(0));
      end
    end
  end

  initial begin
    bus.Start = 1'b0; bus.Signed = 1'b0; bus.Dividend = '0; bus.Divisor = '0;
    repeat (3) @(posedge Clk); #1;
    chk("rst_busy", 64'(bus.Busy),      64'(0));
    chk("rst_done", 64'(bus.Done),      64'(0));
    chk("rst_quo",  64'(bus.Quotient),  64'(0));
    chk("rst_rem",  64'(bus.Remainder), 64'(0));
    chk("rst_dbz",  64'(bus.DivByZero), 64'(0));
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT, "u100_7");
    @(negedge Clk);
    chk("busy_during_calc", 64'(bus.Busy), 64'(1));
    wait_done("u100_7");
    repeat (2) @(negedge Clk);

    op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT, "s_m7_2");
    wait_done("s_m7_2");
    op(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, LAT, "u_m7_2");
    wait_done("u_m7_2");
    op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, LAT, "s_7_m2");
    wait_done("s_7_m2");
    repeat (3) @(negedge Clk);

    op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0 | 1'b1, 2, "u_div0");
    wait_done("u_div0");
    op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, "s_div0");
    wait_done("s_div0");
    op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, LAT, "s_ovf");
    wait_done("s_ovf");
    op(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, FPL, "u_small");
    wait_done("u_small");
    op(1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, 1'b0, FPL, "s_small");
    wait_done("s_small");
    repeat (2) @(negedge Clk);

    // A second Start mid-operation must be ignored; the first result stands.
    op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT, "ign_first");
    repeat (8) @(negedge Clk);
    bus.Signed = 1'b1; bus.Dividend = 32'd9; bus.Divisor = 32'd3; bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    wait_done("ign_first");
    // Start in the Done cycle is accepted back-to-back.
    op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, LAT, "b2b");
    wait_done("b2b");
    repeat (2) @(negedge Clk);

    op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT, "aborted");
    repeat (9) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.Busy),      64'(0));
    chk("abort_done", 64'(bus.Done),      64'(0));
    chk("abort_quo",  64'(bus.Quotient),  64'(0));
    chk("abort_rem",  64'(bus.Remainder), 64'(0));
    chk("abort_dbz",  64'(bus.DivByZero), 64'(0));
    sb.delete();
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (40) @(negedge Clk);
    op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT, "after_rst");
    wait_done("after_rst");
    repeat (40) @(negedge Clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
